yx_kz: RTL

- Run/timing controller, directly downstream of the console interface.
- Consumes its latched mode flags (TBtj, DP, DZQ, DZL, LS), console request KTQQ and console instruction ZLkt.
- Sequences machine cycles STOP / KT / QZ / JZ / ZX, each of 4 beats P0..P3. Drives the run, console and cycle status lines and beat strobes.
- Returns one-cycle Z0* clear pulses to the console interface.

---
 rtl/yx_kz_pkg.sv | 28 ++
 rtl/yx_kz_jp_gen.sv | 39 +++
 rtl/yx_kz.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/yx_kz_pkg.sv
// yx_kz_pkg: shared constants and types for the run/timing controller.
// Holds the machine-cycle state encoding, beat count and console codes.
// Latency: n/a (declarations only). Backpressure: n/a.
package yx_kz_pkg;

  // Beats per machine cycle (P0..P(N_BEAT-1)); must be at least 2.
  localparam int N_BEAT = 4;
  localparam int BW     = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;

  // Console instruction codes.
  localparam logic [7:0] ZL_QDZ = 8'hFB;  // start at address -> run after KT
  localparam logic [7:0] ZL_YD  = 8'hFD;  // bootstrap        -> run after KT
  localparam logic [7:0] ZL_CZ  = 8'hDF;  // plain console op -> back to STOP

  typedef enum logic [2:0] {
    ST_STOP = 3'd0,
    ST_KT   = 3'd1,
    ST_QZ   = 3'd2,
    ST_JZ   = 3'd3,
    ST_ZX   = 3'd4
  } st_t;

  // True for console codes whose KT cycle hands over to a program run.
  function automatic logic is_run_code(input logic [7:0] code);
    return (code == ZL_QDZ) || (code == ZL_YD);
  endfunction

endpackage

// File: rtl/yx_kz_jp_gen.sv
// jp_gen: beat counter for one machine cycle, with load, clear, wrap flag, one-hot decode.
// Ports: clk/rst, en (advance), load/load_val (resume beat), clr (back to P0), beat, last, onehot.
// Latency: 1 clock from control to beat. Backpressure: none; holds when en=0.
module jp_gen #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic [W-1:0] beat,
  output logic         last,
  output logic [N-1:0] onehot
);

  assign last = (beat == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (load) begin
      beat <= load_val;
    end else if (clr) begin
      beat <= '0;
    end else if (en) begin
      // Wrapping to P0 is what marks the machine-cycle boundary.
      beat <= last ? '0 : beat + W'(1);
    end
  end

  always_comb begin
    onehot       = '0;
    onehot[beat] = 1'b1;
  end

endmodule

// File: rtl/yx_kz.sv
// yx_kz: run/timing controller sequencing STOP/KT/QZ/JZ/ZX machine cycles of N_BEAT beats.
// Ports: i_m_x clock, rst sync reset, console flags/request/code in; status, beat strobes,
//   latched console code, Z0 clear pulses, interrupt ack and sticky parity-stop indicator out.
// Latency: 1 clock from accepted LS/KTQQ to first beat; all pulses registered, one clock wide.
module yx_kz
  import yx_kz_pkg::*;
(
  input  logic              i_m_x,
  input  logic              rst,
  input  logic              i_TBtj,
  input  logic              i_DP,
  input  logic              i_DZQ,
  input  logic              i_DZL,
  input  logic              i_LS,
  input  logic              i_KTQQ,
  input  logic [7:0]        i_ZLkt,
  input  logic              i_JZ_req,
  input  logic              i_ZD_req,
  input  logic              i_Cjyc,
  output logic              o_YX,
  output logic              o_KTZT,
  output logic              o_QZZT,
  output logic              o_JZZT,
  output logic              o_ZXZT,
  output logic [N_BEAT-1:0] o_P,
  output logic [7:0]        o_KTZL,
  output logic              o_Z0TBtj,
  output logic              o_Z0DP,
  output logic              o_Z0DZQ,
  output logic              o_Z0DZL,
  output logic              o_Z0LS,
  output logic              o_Z0KTQQ,
  output logic              o_ZDXY,
  output logic              o_ERR
);

  st_t            st;
  st_t            sv_st;      // state to resume after a DP/DZQ stop
  logic [BW-1:0]  sv_beat;    // beat to resume after a DP/DZQ stop
  logic           hold;
  logic           stop_req;
  logic           m_dp, m_dzq, m_dzl;

  logic [BW-1:0]     beat;
  logic              last;
  logic [N_BEAT-1:0] onehot;

  logic          running;
  logic          kt_acc, ls_acc;
  logic          sreq_eff;
  logic          stop_err, stop_ie, stop_hold;
  logic          cnt_en, cnt_load, cnt_clr;
  logic [BW-1:0] cnt_load_val;
  logic [BW-1:0] nxt_beat;
  st_t           cyc_nxt;

  // ---------------------------------------------------------------------------
  // Per-clock decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    running  = (st == ST_QZ) || (st == ST_JZ) || (st == ST_ZX);
    kt_acc   = (st == ST_STOP) && i_KTQQ;
    ls_acc   = (st == ST_STOP) && !i_KTQQ && i_LS;
    // A TBtj arriving in the final beat still counts for this instruction.
    sreq_eff = stop_req || i_TBtj;
    nxt_beat = last ? '0 : beat + BW'(1);

    cyc_nxt = ST_STOP;
    case (st)
      ST_QZ:   cyc_nxt = i_JZ_req ? ST_JZ : ST_ZX;
      ST_JZ:   cyc_nxt = i_JZ_req ? ST_JZ : ST_ZX;
      ST_ZX:   cyc_nxt = ST_QZ;
      default: cyc_nxt = ST_STOP;
    endcase

    // Stop priority: parity error, then instruction-end stop, then single-step stops.
    stop_err  = running && i_Cjyc;
    stop_ie   = running && !i_Cjyc && (st == ST_ZX) && last && (sreq_eff || m_dzl);
    stop_hold = running && !i_Cjyc && !stop_ie && (m_dp || (m_dzq && last));

    cnt_en       = running || (st == ST_KT);
    cnt_load     = kt_acc || ls_acc;
    cnt_load_val = (ls_acc && hold) ? sv_beat : '0;
    cnt_clr      = stop_err || stop_ie || stop_hold;
  end

  jp_gen #(
    .N (N_BEAT),
    .W (BW)
  ) u_jp_gen (
    .clk      (i_m_x),
    .rst      (rst),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .clr      (cnt_clr),
    .beat     (beat),
    .last     (last),
    .onehot   (onehot)
  );

  // ---------------------------------------------------------------------------
  // Machine-cycle FSM with registered pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_m_x) begin
    if (rst) begin
      st       <= ST_STOP;
      sv_st    <= ST_STOP;
      sv_beat  <= '0;
      hold     <= 1'b0;
      stop_req <= 1'b0;
      m_dp     <= 1'b0;
      m_dzq    <= 1'b0;
      m_dzl    <= 1'b0;
      o_KTZL   <= '0;
      o_ERR    <= 1'b0;
      o_Z0TBtj <= 1'b0;
      o_Z0DP   <= 1'b0;
      o_Z0DZQ  <= 1'b0;
      o_Z0DZL  <= 1'b0;
      o_Z0LS   <= 1'b0;
      o_Z0KTQQ <= 1'b0;
      o_ZDXY   <= 1'b0;
    end else begin
      o_Z0TBtj <= 1'b0;
      o_Z0DP   <= 1'b0;
      o_Z0DZQ  <= 1'b0;
      o_Z0DZL  <= 1'b0;
      o_Z0LS   <= 1'b0;
      o_Z0KTQQ <= 1'b0;
      o_ZDXY   <= 1'b0;

      case (st)
        ST_STOP: begin
          if (i_KTQQ) begin
            o_KTZL   <= i_ZLkt;
            o_Z0KTQQ <= 1'b1;
            hold     <= 1'b0;
            st       <= ST_KT;
          end else if (i_LS) begin
            o_Z0LS  <= 1'b1;
            m_dp    <= i_DP;
            m_dzq   <= i_DZQ;
            m_dzl   <= i_DZL;
            o_Z0DP  <= i_DP;
            o_Z0DZQ <= i_DZQ;
            o_Z0DZL <= i_DZL;
            o_ERR   <= 1'b0;
            if (hold) begin
              hold <= 1'b0;
              st   <= sv_st;
            end else begin
              stop_req <= 1'b0;
              st       <= ST_QZ;
            end
          end
        end

        ST_KT: begin
          if (last) begin
            if (is_run_code(o_KTZL)) begin
              m_dp  <= 1'b0;
              m_dzq <= 1'b0;
              m_dzl <= 1'b0;
              st    <= ST_QZ;
            end else begin
              st <= ST_STOP;
            end
          end
        end

        ST_QZ, ST_JZ, ST_ZX: begin
          if (i_TBtj) stop_req <= 1'b1;

          if (stop_err) begin
            st    <= ST_STOP;
            hold  <= 1'b0;
            o_ERR <= 1'b1;
          end else if (stop_ie) begin
            st       <= ST_STOP;
            hold     <= 1'b0;
            o_Z0TBtj <= sreq_eff;
            stop_req <= 1'b0;
          end else if (stop_hold) begin
            st      <= ST_STOP;
            hold    <= 1'b1;
            sv_st   <= last ? cyc_nxt : st;
            sv_beat <= nxt_beat;
          end else if (last) begin
            st <= cyc_nxt;
            if ((st == ST_ZX) && i_ZD_req) o_ZDXY <= 1'b1;
          end
        end

        default: st <= ST_STOP;
      endcase
    end
  end

  // Status lines decode straight from the registered state.
  assign o_YX   = (st == ST_QZ) || (st == ST_JZ) || (st == ST_ZX);
  assign o_KTZT = (st == ST_KT);
  assign o_QZZT = (st == ST_QZ);
  assign o_JZZT = (st == ST_JZ);
  assign o_ZXZT = (st == ST_ZX);
  assign o_P    = (st == ST_STOP) ? '0 : onehot;

endmodule
